// File: rtl/proc_core_if.sv
// Memory bus between proc_core and its zero-wait memory.
interface proc_core_if;
    logic [15:0] address;
    logic [7:0]  rd_data;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        sync;

    modport master (
        output address,
        output wr_data,
        output wr_en,
        output sync,
        input  rd_data
    );

    modport slave (
        input  address,
        input  wr_data,
        input  wr_en,
        input  sync,
        output rd_data
    );
endinterface

// File: rtl/proc_core.sv
// Minimal 8-bit 6502-style core: reset vector fetch, a small opcode subset,
// one bus cycle per clock against a zero-wait memory.
module proc_core #(
    parameter logic [15:0] RESET_VEC    = 16'hFFFC,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    proc_core_if.master       bus,
    output logic              halted,
    output logic [7:0]        dbg_a,
    output logic [7:0]        dbg_x,
    output logic [7:0]        dbg_y,
    output logic [15:0]       dbg_pc,
    output logic [1:0]        dbg_nz
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_JMP     = 8'h4C;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_INY     = 8'hC8;
    localparam logic [7:0] OP_DEX     = 8'hCA;
    localparam logic [7:0] OP_DEY     = 8'h88;
    localparam logic [7:0] OP_TAX     = 8'hAA;

    typedef enum logic [7:0] {
        S_RESET  = 8'b0000_0001,
        S_VEC_LO = 8'b0000_0010,
        S_VEC_HI = 8'b0000_0100,
        S_FETCH  = 8'b0000_1000,
        S_DECODE = 8'b0001_0000,
        S_ABS_HI = 8'b0010_0000,
        S_MEM    = 8'b0100_0000,
        S_HALT   = 8'b1000_0000
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   x_q, x_d;
    logic [DW-1:0]   y_q, y_d;
    logic [DW-1:0]   ir_q, ir_d;
    logic [DW-1:0]   opl_q, opl_d;
    logic            n_q, n_d;
    logic            z_q, z_d;
    logic [DW-1:0]   res;
    logic            set_nz;

    // Opcodes this core implements; anything else is illegal.
    function automatic logic is_supported(input logic [7:0] op);
        case (op)
            OP_NOP, OP_JMP, OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM,
            OP_LDA_ABS, OP_STA_ABS, OP_INX, OP_INY, OP_DEX,
            OP_DEY, OP_TAX: is_supported = 1'b1;
            default:        is_supported = 1'b0;
        endcase
    endfunction

    // Next-state, datapath and bus outputs for the current cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        ir_d    = ir_q;
        opl_d   = opl_q;
        n_d     = n_q;
        z_d     = z_q;
        res     = '0;
        set_nz  = 1'b0;

        unique case (state_q)
            S_RESET: begin
                addr_d  = RESET_VEC;
                state_d = S_VEC_LO;
            end
            S_VEC_LO: begin
                pc_d    = {pc_q[15:8], bus.rd_data};
                addr_d  = RESET_VEC + 16'd1;
                state_d = S_VEC_HI;
            end
            S_VEC_HI: begin
                pc_d    = {bus.rd_data, pc_q[7:0]};
                addr_d  = {bus.rd_data, pc_q[7:0]};
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d   = bus.rd_data;
                pc_d   = pc_q + 16'd1;
                addr_d = pc_q + 16'd1;
                if (ILLEGAL_HALT && !is_supported(bus.rd_data)) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (ir_q)
                    OP_LDA_IMM: begin
                        a_d    = bus.rd_data;
                        res    = bus.rd_data;
                        set_nz = 1'b1;
                        pc_d   = pc_q + 16'd1;
                        addr_d = pc_q + 16'd1;
                    end
                    OP_LDX_IMM: begin
                        x_d    = bus.rd_data;
                        res    = bus.rd_data;
                        set_nz = 1'b1;
                        pc_d   = pc_q + 16'd1;
                        addr_d = pc_q + 16'd1;
                    end
                    OP_LDY_IMM: begin
                        y_d    = bus.rd_data;
                        res    = bus.rd_data;
                        set_nz = 1'b1;
                        pc_d   = pc_q + 16'd1;
                        addr_d = pc_q + 16'd1;
                    end
                    OP_JMP, OP_LDA_ABS, OP_STA_ABS: begin
                        opl_d   = bus.rd_data;
                        pc_d    = pc_q + 16'd1;
                        addr_d  = pc_q + 16'd1;
                        state_d = S_ABS_HI;
                    end
                    OP_INX: begin
                        x_d    = x_q + 8'd1;
                        res    = x_d;
                        set_nz = 1'b1;
                    end
                    OP_INY: begin
                        y_d    = y_q + 8'd1;
                        res    = y_d;
                        set_nz = 1'b1;
                    end
                    OP_DEX: begin
                        x_d    = x_q - 8'd1;
                        res    = x_d;
                        set_nz = 1'b1;
                    end
                    OP_DEY: begin
                        y_d    = y_q - 8'd1;
                        res    = y_d;
                        set_nz = 1'b1;
                    end
                    OP_TAX: begin
                        x_d    = a_q;
                        res    = a_q;
                        set_nz = 1'b1;
                    end
                    // NOP, and illegal opcodes when they are not halting
                    default: begin
                    end
                endcase
            end
            S_ABS_HI: begin
                if (ir_q == OP_JMP) begin
                    pc_d    = {bus.rd_data, opl_q};
                    addr_d  = {bus.rd_data, opl_q};
                    state_d = S_FETCH;
                end else begin
                    pc_d    = pc_q + 16'd1;
                    addr_d  = {bus.rd_data, opl_q};
                    state_d = S_MEM;
                    if (ir_q == OP_STA_ABS) begin
                        wen_d   = 1'b1;
                        wdata_d = a_q;
                    end
                end
            end
            S_MEM: begin
                if (ir_q == OP_LDA_ABS) begin
                    a_d    = bus.rd_data;
                    res    = bus.rd_data;
                    set_nz = 1'b1;
                end
                addr_d  = pc_q;
                state_d = S_FETCH;
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (set_nz) begin
            n_d = res[7];
            z_d = (res == 8'h00);
        end
    end

    // State and datapath registers; reset overrides any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            addr_q  <= '0;
            pc_q    <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            a_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ir_q    <= '0;
            opl_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ir_q    <= ir_d;
            opl_q   <= opl_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    assign bus.address = addr_q;
    assign bus.wr_data = wdata_q;
    assign bus.wr_en   = wen_q;
    assign bus.sync    = (state_q == S_FETCH);
    assign halted      = (state_q == S_HALT);
    assign dbg_a       = a_q;
    assign dbg_x       = x_q;
    assign dbg_y       = y_q;
    assign dbg_pc      = pc_q;
    assign dbg_nz      = {n_q, z_q};

endmodule

// File: tb/tb_proc_core.sv
// Scoreboarded bench for proc_core: expected fetches and writes are queued
// per program and retired by a bus monitor as the core produces them.
module tb_proc_core;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  a;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [1:0]  nz;
        int          gap;
    } fetch_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = -1;

    fetch_t fq[$];
    wr_t    wq[$];

    bit [7:0]    rom [65536];
    bit [7:0]    ram [65536];
    int unsigned ram_gen [65536];
    int unsigned gen = 1;

    proc_core_if bus_h();
    proc_core_if bus_n();

    logic        h_halted, n_halted;
    logic [7:0]  h_a, h_x, h_y, n_a, n_x, n_y;
    logic [15:0] h_pc, n_pc;
    logic [1:0]  h_nz, n_nz;

    proc_core #(.RESET_VEC(16'hFFFC), .ILLEGAL_HALT(1'b1)) dut_h (
        .clk(clk), .reset(reset), .bus(bus_h), .halted(h_halted),
        .dbg_a(h_a), .dbg_x(h_x), .dbg_y(h_y), .dbg_pc(h_pc), .dbg_nz(h_nz)
    );

    proc_core #(.RESET_VEC(16'hFFFC), .ILLEGAL_HALT(1'b0)) dut_n (
        .clk(clk), .reset(reset), .bus(bus_n), .halted(n_halted),
        .dbg_a(n_a), .dbg_x(n_x), .dbg_y(n_y), .dbg_pc(n_pc), .dbg_nz(n_nz)
    );

    always #5 clk = ~clk;

    // Zero-wait memory: bytes stored by the core this run shadow the program image.
    assign bus_h.rd_data = (ram_gen[bus_h.address] == gen) ? ram[bus_h.address] : rom[bus_h.address];
    assign bus_n.rd_data = rom[bus_n.address];

    always @(posedge clk) begin
        if (bus_h.wr_en === 1'b1) begin
            ram[bus_h.address]     <= bus_h.wr_data;
            ram_gen[bus_h.address] <= gen;
        end
    end

    // Bus monitor: retire expected fetches (with cycle spacing) and writes.
    always @(negedge clk) begin
        fetch_t f;
        wr_t    w;
        if (reset) cyc = -1;
        else       cyc++;
        if (mon_en && reset === 1'b0) begin
            if (bus_h.sync === 1'b1) begin
                vec_cnt++;
                if (fq.size() == 0) begin
                    err_cnt++;
                    $display("FAIL fetch_unexpected: got fetch at %h, none expected", bus_h.address);
                end else begin
                    f = fq.pop_front();
                    if (bus_h.address !== f.addr || h_pc !== f.addr || h_a !== f.a || h_x !== f.x ||
                        h_y !== f.y || h_nz !== f.nz || cyc != f.gap) begin
                        err_cnt++;
                        $display("FAIL fetch_%h: got addr=%h pc=%h a=%h x=%h y=%h nz=%b gap=%0d, want addr=%h a=%h x=%h y=%h nz=%b gap=%0d",
                                 f.addr, bus_h.address, h_pc, h_a, h_x, h_y, h_nz, cyc,
                                 f.addr, f.a, f.x, f.y, f.nz, f.gap);
                    end
                end
                cyc = 0;
            end
            if (bus_h.wr_en === 1'b1) begin
                vec_cnt++;
                if (wq.size() == 0) begin
                    err_cnt++;
                    $display("FAIL write_unexpected: got write %h to %h, none expected", bus_h.wr_data, bus_h.address);
                end else begin
                    w = wq.pop_front();
                    if (bus_h.address !== w.addr || bus_h.wr_data !== w.data) begin
                        err_cnt++;
                        $display("FAIL write_%h: got addr=%h data=%h, want addr=%h data=%h",
                                 w.addr, bus_h.address, bus_h.wr_data, w.addr, w.data);
                    end
                end
            end
        end
    end

    function automatic void exp_fetch(input logic [15:0] addr, input logic [7:0] a, input logic [7:0] x,
                                      input logic [7:0] y, input logic [1:0] nz, input int gap);
        fetch_t f;
        f.addr = addr; f.a = a; f.x = x; f.y = y; f.nz = nz; f.gap = gap;
        fq.push_back(f);
    endfunction

    function automatic void exp_write(input logic [15:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wq.push_back(w);
    endfunction

    // Fresh program image with the reset vector pointing at 8000.
    task automatic new_image();
        foreach (rom[i]) rom[i] = 8'h00;
        gen++;
        rom[16'hFFFC] = 8'h00;
        rom[16'hFFFD] = 8'h80;
    endtask

    task automatic load(input logic [15:0] base, input logic [7:0] bytes[$]);
        logic [15:0] a;
        a = base;
        foreach (bytes[i]) begin
            rom[a] = bytes[i];
            a = a + 16'd1;
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        new_image();
        load(16'h8000, '{8'hEA, 8'hEA, 8'h00});
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if (bus_h.address !== 16'h0000 || bus_h.wr_en !== 1'b0 || bus_h.wr_data !== 8'h00 ||
            h_a !== 8'h00 || h_x !== 8'h00 || h_y !== 8'h00 || h_pc !== 16'h0000 ||
            h_nz !== 2'b00 || bus_h.sync !== 1'b0 || h_halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: got addr=%h we=%b wd=%h a=%h x=%h y=%h pc=%h nz=%b sync=%b halt=%b, want all zero",
                     bus_h.address, bus_h.wr_en, bus_h.wr_data, h_a, h_x, h_y, h_pc, h_nz, bus_h.sync, h_halted);
        end
        mon_en = 1'b1;
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h8001, 8'h00, 8'h00, 8'h00, 2'b00, 2);
        exp_fetch(16'h8002, 8'h00, 8'h00, 8'h00, 2'b00, 2);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] want_addr;
            logic        want_sync;
            @(negedge clk);
            case (k)
                0:       begin want_addr = 16'h0000; want_sync = 1'b0; end
                1:       begin want_addr = 16'hFFFC; want_sync = 1'b0; end
                2:       begin want_addr = 16'hFFFD; want_sync = 1'b0; end
                default: begin want_addr = 16'h8000; want_sync = 1'b1; end
            endcase
            vec_cnt++;
            if (bus_h.address !== want_addr || bus_h.sync !== want_sync || h_halted !== 1'b0) begin
                err_cnt++;
                $display("FAIL vector_seq_%0d: got addr=%h sync=%b halt=%b, want addr=%h sync=%b halt=0",
                         k, bus_h.address, bus_h.sync, h_halted, want_addr, want_sync);
            end
        end
        repeat (10) @(negedge clk);
        vec_cnt++;
        if (fq.size() != 0 || h_halted !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_drain: got %0d fetches pending halt=%b, want 0 pending halt=1", fq.size(), h_halted);
        end
    endtask

    task automatic test_load_inc();
        new_image();
        load(16'h8000, '{8'hA9, 8'h00, 8'hA2, 8'hFF, 8'hE8, 8'hEA, 8'h00});
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h8002, 8'h00, 8'h00, 8'h00, 2'b01, 2);
        exp_fetch(16'h8004, 8'h00, 8'hFF, 8'h00, 2'b10, 2);
        exp_fetch(16'h8005, 8'h00, 8'h00, 8'h00, 2'b01, 2);
        exp_fetch(16'h8006, 8'h00, 8'h00, 8'h00, 2'b01, 2);
        do_reset();
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (fq.size() != 0) begin
            err_cnt++;
            $display("FAIL load_inc_drain: got %0d fetches pending, want 0", fq.size());
        end
    endtask

    task automatic test_reg_ops();
        new_image();
        load(16'h8000, '{8'hA0, 8'h80, 8'h88, 8'hC8, 8'hA2, 8'h00, 8'hCA, 8'hA9, 8'h01, 8'hAA, 8'h00});
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h8002, 8'h00, 8'h00, 8'h80, 2'b10, 2);
        exp_fetch(16'h8003, 8'h00, 8'h00, 8'h7F, 2'b00, 2);
        exp_fetch(16'h8004, 8'h00, 8'h00, 8'h80, 2'b10, 2);
        exp_fetch(16'h8006, 8'h00, 8'h00, 8'h80, 2'b01, 2);
        exp_fetch(16'h8007, 8'h00, 8'hFF, 8'h80, 2'b10, 2);
        exp_fetch(16'h8009, 8'h01, 8'hFF, 8'h80, 2'b00, 2);
        exp_fetch(16'h800A, 8'h01, 8'h01, 8'h80, 2'b00, 2);
        do_reset();
        repeat (25) @(negedge clk);
        vec_cnt++;
        if (fq.size() != 0) begin
            err_cnt++;
            $display("FAIL reg_ops_drain: got %0d fetches pending, want 0", fq.size());
        end
    endtask

    task automatic test_store_load();
        new_image();
        load(16'h8000, '{8'hA9, 8'h5A, 8'hA2, 8'h80, 8'h8D, 8'h34, 8'h12,
                         8'hA9, 8'h00, 8'hAD, 8'h34, 8'h12, 8'h00});
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h8002, 8'h5A, 8'h00, 8'h00, 2'b00, 2);
        exp_fetch(16'h8004, 8'h5A, 8'h80, 8'h00, 2'b10, 2);
        exp_fetch(16'h8007, 8'h5A, 8'h80, 8'h00, 2'b10, 4);
        exp_fetch(16'h8009, 8'h00, 8'h80, 8'h00, 2'b01, 2);
        exp_fetch(16'h800C, 8'h5A, 8'h80, 8'h00, 2'b00, 4);
        exp_write(16'h1234, 8'h5A);
        do_reset();
        repeat (25) @(negedge clk);
        vec_cnt++;
        if (fq.size() != 0 || wq.size() != 0) begin
            err_cnt++;
            $display("FAIL store_load_drain: got %0d fetches %0d writes pending, want 0 and 0", fq.size(), wq.size());
        end
    endtask

    task automatic test_jmp();
        new_image();
        load(16'h8000, '{8'h4C, 8'h00, 8'h90});
        load(16'h9000, '{8'h4C, 8'hFF, 8'hFF});
        rom[16'hFFFF] = 8'hE8;
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h9000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'hFFFF, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h0000, 8'h00, 8'h01, 8'h00, 2'b00, 2);
        do_reset();
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (fq.size() != 0 || h_halted !== 1'b1 || bus_h.address !== 16'h0001) begin
            err_cnt++;
            $display("FAIL jmp_drain: got %0d pending halt=%b addr=%h, want 0 pending halt=1 addr=0001",
                     fq.size(), h_halted, bus_h.address);
        end
    endtask

    task automatic test_illegal();
        new_image();
        load(16'h8000, '{8'hA9, 8'h7F, 8'h02, 8'hE8, 8'h00});
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h8002, 8'h7F, 8'h00, 8'h00, 2'b00, 2);
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 6) begin
                vec_cnt++;
                if (h_halted !== 1'b1 || bus_h.address !== 16'h8003 || h_pc !== 16'h8003 ||
                    bus_h.sync !== 1'b0 || bus_h.wr_en !== 1'b0 || h_a !== 8'h7F) begin
                    err_cnt++;
                    $display("FAIL halt_hold_%0d: got halt=%b addr=%h pc=%h sync=%b we=%b a=%h, want halt=1 addr=8003 pc=8003 sync=0 we=0 a=7f",
                             k, h_halted, bus_h.address, h_pc, bus_h.sync, bus_h.wr_en, h_a);
                end
            end
            if (k == 7) begin
                vec_cnt++;
                if (n_halted !== 1'b0 || bus_n.sync !== 1'b1 || bus_n.address !== 16'h8003 ||
                    n_pc !== 16'h8003 || bus_n.wr_en !== 1'b0 || n_a !== 8'h7F) begin
                    err_cnt++;
                    $display("FAIL illegal_nop_fetch: got halt=%b sync=%b addr=%h pc=%h we=%b a=%h, want halt=0 sync=1 addr=8003 pc=8003 we=0 a=7f",
                             n_halted, bus_n.sync, bus_n.address, n_pc, bus_n.wr_en, n_a);
                end
            end
            if (k == 9) begin
                vec_cnt++;
                if (bus_n.sync !== 1'b1 || bus_n.address !== 16'h8004 || n_x !== 8'h01 ||
                    n_y !== 8'h00 || n_nz !== 2'b00 || bus_n.wr_data !== 8'h00) begin
                    err_cnt++;
                    $display("FAIL illegal_nop_next: got sync=%b addr=%h x=%h y=%h nz=%b wd=%h, want sync=1 addr=8004 x=01 y=00 nz=00 wd=00",
                             bus_n.sync, bus_n.address, n_x, n_y, n_nz, bus_n.wr_data);
                end
            end
        end
        vec_cnt++;
        if (fq.size() != 0) begin
            err_cnt++;
            $display("FAIL illegal_drain: got %0d fetches pending, want 0", fq.size());
        end
    endtask

    task automatic test_reset_during_sta();
        bit seen;
        new_image();
        load(16'h8000, '{8'hA9, 8'h33, 8'h8D, 8'h00, 8'h20, 8'h00});
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h8002, 8'h33, 8'h00, 8'h00, 2'b00, 2);
        exp_write(16'h2000, 8'h33);
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus_h.wr_en === 1'b1) seen = 1'b1;
        end
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL sta_timeout: got no wr_en within 20 cycles, want one");
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if (bus_h.wr_en !== 1'b0 || bus_h.address !== 16'h0000 || bus_h.wr_data !== 8'h00 ||
            h_a !== 8'h00 || h_x !== 8'h00 || h_y !== 8'h00 || h_pc !== 16'h0000 ||
            h_nz !== 2'b00 || bus_h.sync !== 1'b0 || h_halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_in_mem: got we=%b addr=%h wd=%h a=%h x=%h y=%h pc=%h nz=%b sync=%b halt=%b, want all zero",
                     bus_h.wr_en, bus_h.address, bus_h.wr_data, h_a, h_x, h_y, h_pc, h_nz, bus_h.sync, h_halted);
        end
        exp_fetch(16'h8000, 8'h00, 8'h00, 8'h00, 2'b00, 3);
        exp_fetch(16'h8002, 8'h33, 8'h00, 8'h00, 2'b00, 2);
        exp_fetch(16'h8005, 8'h33, 8'h00, 8'h00, 2'b00, 4);
        exp_write(16'h2000, 8'h33);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                vec_cnt++;
                if (bus_h.address !== 16'hFFFC) begin
                    err_cnt++;
                    $display("FAIL revector: got addr=%h, want fffc", bus_h.address);
                end
            end
        end
        repeat (15) @(negedge clk);
        vec_cnt++;
        if (fq.size() != 0 || wq.size() != 0) begin
            err_cnt++;
            $display("FAIL reset_sta_drain: got %0d fetches %0d writes pending, want 0 and 0", fq.size(), wq.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_inc();
        test_reg_ops();
        test_store_load();
        test_jmp();
        test_illegal();
        test_reset_during_sta();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/proc_core.md
PROC_CORE -- requirements
Module: proc_core

Interface
REQ-001 Parameter RESET_VEC, 16'hFFFC, address of reset-vector low byte; high byte is read from RESET_VEC+1 (16-bit wrap).
REQ-002 Parameter ILLEGAL_HALT, 1, 1 = unsupported opcode enters HALT; 0 = unsupported opcode executes as 2-cycle NOP.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rd_data  in  8  memory contents at current address; zero-wait read, valid in the same cycle address is presented.
REQ-006 address  out  16  registered bus address.
REQ-007 wr_data  out  8  registered write data, meaningful only when wr_en=1.
REQ-008 wr_en  out  1  registered write strobe; memory writes wr_data to address on the edge ending the cycle.
REQ-009 sync  out  1  high exactly in FETCH cycles (opcode being read).
REQ-010 halted  out  1  high while in HALT.
REQ-011 dbg_a, dbg_x, dbg_y  out  8 each  current A, X, Y.
REQ-012 dbg_pc  out  16  current PC.
REQ-013 dbg_nz  out  2  {N,Z} flags.

Function
REQ-014 States: RESET, VEC_LO, VEC_HI, FETCH, DECODE, ABS_HI, MEM, HALT; one-hot encoded.
REQ-015 RESET->VEC_LO: address<=RESET_VEC.
REQ-016 VEC_LO: PC[7:0]<=rd_data; address<=RESET_VEC+1; ->VEC_HI.
REQ-017 VEC_HI: PC<={rd_data,PC[7:0]}; address<={rd_data,PC[7:0]}; ->FETCH; first sync occurs 3 cycles after reset release.
REQ-018 FETCH: IR<=rd_data; PC<=PC+1; address<=PC+1; ->DECODE, or ->HALT if rd_data unsupported and ILLEGAL_HALT=1.
REQ-019 Supported opcodes: NOP EA, JMP abs 4C, LDA imm A9, LDX imm A2, LDY imm A0, LDA abs AD, STA abs 8D, INX E8, INY C8, DEX CA, DEY 88, TAX AA.
REQ-020 DECODE, implied (NOP/INX/INY/DEX/DEY/TAX/illegal-as-NOP): perform operation; PC and address unchanged; ->FETCH (2 cycles total).
REQ-021 DECODE, immediate: target register<=rd_data; PC<=PC+1; address<=PC+1; ->FETCH (2 cycles).
REQ-022 DECODE, absolute: OPL<=rd_data; PC<=PC+1; address<=PC+1; ->ABS_HI.
REQ-023 ABS_HI, JMP: PC<={rd_data,OPL}; address<={rd_data,OPL}; ->FETCH (3 cycles).
REQ-024 ABS_HI, LDA/STA: PC<=PC+1; address<={rd_data,OPL}; STA also wr_en<=1, wr_data<=A; ->MEM.
REQ-025 MEM: LDA sets A<=rd_data; wr_en<=0; address<=PC; ->FETCH (LDA/STA 4 cycles); wr_en is high for exactly the MEM cycle.
REQ-026 N<=result[7], Z<=(result==0) on LDA, LDX, LDY, INX, INY, DEX, DEY, TAX; NOP, JMP, STA leave flags unchanged.
REQ-027 Increment/decrement and PC arithmetic wrap modulo 2^8 / 2^16 (X=FF INX -> 00, Z=1, N=0; X=00 DEX -> FF, N=1; PC FFFF+1 -> 0000).
REQ-028 HALT: all registers and address hold; wr_en=0; sync=0; exit only by reset.
REQ-029 sync and halted are decoded from the state register (no extra cycle delay).

Reset
REQ-030 While reset=1 on an edge: state<=RESET; address=0000, wr_en=0, wr_data=00, A=X=Y=00, PC=0000, N=Z=0, IR=00, OPL=00.
REQ-031 Reset takes priority over every state, including a pending STA write; wr_en is 0 in the cycle after the reset edge.
REQ-032 In RESET state: sync=0, halted=0.

Verification
REQ-033 Vector: mem[FFFC]=00, mem[FFFD]=80, mem[8000]=EA -> address sequence FFFC, FFFD, 8000 after release; sync=1 when address=8000; next fetch at 8001 two cycles later.
REQ-034 Program A9 00, A2 FF, E8 at 8000 -> after LDA A=00,Z=1,N=0; after LDX X=FF,N=1; after INX X=00,Z=1,N=0; cycles 2+2+2.
REQ-035 Program A9 5A, 8D 34 12, AD 34 12 -> wr_en=1 for one cycle with address=1234, wr_data=5A; LDA abs returns A=5A; STA 4 cycles, flags unchanged by STA.
REQ-036 JMP: 4C 00 90 at 8000 -> fetch at 9000 three cycles after fetch of 8000; JMP 4C FF FF then opcode E8 at FFFF -> next fetch at 0000.
REQ-037 Opcode 02 with ILLEGAL_HALT=1 -> halted=1 next cycle, address frozen; with ILLEGAL_HALT=0 -> 2-cycle NOP, fetch continues.
REQ-038 reset asserted during STA MEM cycle -> wr_en=0 next cycle, all outputs at REQ-030 values, vector re-read.
